// File: rtl/tft_pkg.sv
// Shared types and constants for the TFT SPI transmit stream.
package tft_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int WORD_W      = 16;
   localparam int BITS_NARROW = 8;
   localparam int BITS_WIDE   = 16;

   // One queued word: width flag, D/C bit and payload (8-bit words use [7:0]).
   typedef struct packed {
      logic              wide;
      logic              dc;
      logic [WORD_W-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/tft_word_fifo.sv
// Synchronous word FIFO with registered occupancy. Head entry is always
// visible on rdata_o; a push is refused while full, even if a pop happens
// in the same cycle.
module tft_word_fifo
   import tft_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  fifo_entry_t              wdata_i,
   output fifo_entry_t              rdata_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   fifo_entry_t       mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW:0]       level_q;
   logic              push_ok;
   logic              pop_ok;

   assign push_ok = push_i && (level_q != FULL_LVL);
   assign pop_ok  = pop_i && (level_q != '0);
   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;

   // Storage array: written on accepted pushes, contents need no reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/tft_spi_stream.sv
// TFT SPI transmit stream: word FIFO, SCK divider and mode-0 serialiser.
// CS stays low across back-to-back words and for CS_HOLD half-periods after
// the FIFO drains, so a late word can still join the same CS frame.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | CS high, SCK low, divider parked; pops as soon as FIFO has data
// SHIFT | word on the wire; each tick toggles SCK, falling tick shifts
// HOLD  | word done, CS still low; counts ticks before releasing CS
module tft_spi_stream
   import tft_pkg::*;
#(
   parameter int CLK_DIV    = 5,
   parameter int FIFO_DEPTH = 16,
   parameter int CS_HOLD    = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [WORD_W-1:0]             in_data,
   input  logic                          in_dc,
   input  logic                          in_wide,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          busy,
   output logic                          tft_clk,
   output logic                          tft_mosi,
   output logic                          tft_dc,
   output logic                          tft_cs
);

   localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HOLD_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;

   localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HOLD - 1);
   localparam logic [4:0]        N_NARROW  = 5'(BITS_NARROW);
   localparam logic [4:0]        N_WIDE    = 5'(BITS_WIDE);

   state_t              state_q;
   logic [DIV_W-1:0]    div_cnt_q;
   logic                phase_q;      // 0: SCK low half, 1: SCK high half
   logic [4:0]          bit_cnt_q;
   logic [WORD_W-1:0]   shreg_q;
   logic [HOLD_W-1:0]   hold_cnt_q;
   logic                cs_q;
   logic                sck_q;
   logic                dc_q;
   logic                busy_q;

   fifo_entry_t         wr_entry;
   fifo_entry_t         head;
   logic [LVL_W-1:0]    level;
   logic                fifo_empty;
   logic                tick;
   logic                last_fall;
   logic                pop;

   assign wr_entry = '{wide: in_wide, dc: in_dc, data: in_data};

   tft_word_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (in_valid),
      .pop_i   (pop),
      .wdata_i (wr_entry),
      .rdata_o (head),
      .level_o (level)
   );

   // Tick and pop decisions for the current cycle.
   always_comb begin
      fifo_empty = (level == '0);
      tick       = (state_q != IDLE) && (div_cnt_q == DIV_LAST);
      last_fall  = (state_q == SHIFT) && tick && phase_q && (bit_cnt_q == 5'd1);
      pop        = 1'b0;
      if (!fifo_empty) begin
         case (state_q)
            IDLE:    pop = 1'b1;
            SHIFT:   pop = last_fall;
            HOLD:    pop = 1'b1;
            default: pop = 1'b0;
         endcase
      end
   end

   // Divider, serialiser and sequencing FSM with registered pin outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         div_cnt_q  <= '0;
         phase_q    <= 1'b0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         hold_cnt_q <= '0;
         cs_q       <= 1'b1;
         sck_q      <= 1'b0;
         dc_q       <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         busy_q <= (state_q != IDLE) || !fifo_empty;

         if (pop || (state_q == IDLE) || tick) begin
            div_cnt_q <= '0;
         end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
         end

         if (pop) begin
            // A load restarts the word with SCK low and MSB already driven.
            state_q    <= SHIFT;
            cs_q       <= 1'b0;
            sck_q      <= 1'b0;
            phase_q    <= 1'b0;
            hold_cnt_q <= '0;
            dc_q       <= head.dc;
            bit_cnt_q  <= head.wide ? N_WIDE : N_NARROW;
            shreg_q    <= head.wide ? head.data : {head.data[7:0], 8'h00};
         end else begin
            case (state_q)
               SHIFT: begin
                  if (tick) begin
                     if (!phase_q) begin
                        sck_q   <= 1'b1;
                        phase_q <= 1'b1;
                     end else begin
                        sck_q   <= 1'b0;
                        phase_q <= 1'b0;
                        if (bit_cnt_q == 5'd1) begin
                           state_q    <= HOLD;
                           bit_cnt_q  <= '0;
                           hold_cnt_q <= '0;
                        end else begin
                           bit_cnt_q <= bit_cnt_q - 5'd1;
                           shreg_q   <= {shreg_q[WORD_W-2:0], 1'b0};
                        end
                     end
                  end
               end
               HOLD: begin
                  if (tick) begin
                     if (hold_cnt_q == HOLD_LAST) begin
                        cs_q       <= 1'b1;
                        state_q    <= IDLE;
                        hold_cnt_q <= '0;
                     end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign in_ready   = (level != FULL_LVL);
   assign fifo_level = level;
   assign busy       = busy_q;
   assign tft_clk    = sck_q;
   assign tft_mosi   = shreg_q[WORD_W-1];
   assign tft_dc     = dc_q;
   assign tft_cs     = cs_q;

endmodule
